alu_arbiter: RTL and testbench

- Shares the single combinational ALU between two requesters: req0 is the core execute stage, req1 is the auxiliary address/branch-target unit.
- Arbitrates round-robin and registers the winning operands and one-hot Operation into an issue stage that drives the ALU.
- Captures ALUResult into a tagged response register.
- Fully pipelined: one operation accepted per cycle, response two cycles after the request cycle, backpressure via rsp_ready.

---
 rtl/alu_arbiter.sv | 146 ++++++++++++++
 tb/tb_alu_arbiter.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters.
// Latency: response valid two cycles after the request cycle; one op per cycle.
// Backpressure: rsp_ready low freezes S2, then S1, then drops both req readies.
module alu_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int OP_WIDTH   = 26,
  parameter logic [OP_WIDTH-1:0] VALID_OP_MASK = 'h07F_FFFF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic [OP_WIDTH-1:0]   req0_op,
  input  logic [DATA_WIDTH-1:0] req0_a,
  input  logic [DATA_WIDTH-1:0] req0_b,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic [OP_WIDTH-1:0]   req1_op,
  input  logic [DATA_WIDTH-1:0] req1_a,
  input  logic [DATA_WIDTH-1:0] req1_b,
  output logic [DATA_WIDTH-1:0] alu_SrcA,
  output logic [DATA_WIDTH-1:0] alu_SrcB,
  output logic [OP_WIDTH-1:0]   alu_Operation,
  input  logic [DATA_WIDTH-1:0] alu_ALUResult,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_id,
  output logic [DATA_WIDTH-1:0] rsp_result,
  output logic                  rsp_err,
  output logic                  busy
);

  // Issue stage (S1) state; op/a/b feed the ALU directly.
  logic                  s1_valid_q, s1_valid_d;
  logic                  s1_id_q, s1_id_d;
  logic [OP_WIDTH-1:0]   s1_op_q, s1_op_d;
  logic [DATA_WIDTH-1:0] s1_a_q, s1_a_d;
  logic [DATA_WIDTH-1:0] s1_b_q, s1_b_d;

  // Response stage (S2) state.
  logic                  rsp_valid_q, rsp_valid_d;
  logic                  rsp_id_q, rsp_id_d;
  logic [DATA_WIDTH-1:0] rsp_result_q, rsp_result_d;
  logic                  rsp_err_q, rsp_err_d;

  // Requester granted by the most recent transfer; 1 so req0 wins first.
  logic last_grant_q, last_grant_d;

  logic s2_load, s1_free;
  logic win0, win1;
  logic xfer0, xfer1;
  logic op_ok;

  // Pipeline advance, arbitration and op-code legality check.
  always_comb begin
    s2_load    = s1_valid_q && (!rsp_valid_q || rsp_ready);
    s1_free    = !s1_valid_q || s2_load;
    win0       = req0_valid && (!req1_valid || last_grant_q);
    win1       = req1_valid && (!req0_valid || !last_grant_q);
    // Ready is forced low while reset is held, even though S1 reads as empty.
    req0_ready = win0 && s1_free && reset;
    req1_ready = win1 && s1_free && reset;
    xfer0      = req0_valid && req0_ready;
    xfer1      = req1_valid && req1_ready;
    op_ok      = (s1_op_q != '0) &&
                 ((s1_op_q & (s1_op_q - OP_WIDTH'(1))) == '0) &&
                 ((s1_op_q & ~VALID_OP_MASK) == '0);
  end

  // Next-state for S1, S2 and the round-robin pointer.
  always_comb begin
    s1_valid_d   = s1_valid_q;
    s1_id_d      = s1_id_q;
    s1_op_d      = s1_op_q;
    s1_a_d       = s1_a_q;
    s1_b_d       = s1_b_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_result_d = rsp_result_q;
    rsp_err_d    = rsp_err_q;
    last_grant_d = last_grant_q;

    if (s2_load) begin
      rsp_valid_d  = 1'b1;
      rsp_id_d     = s1_id_q;
      rsp_result_d = alu_ALUResult;  // forwarded as-is even for illegal ops
      rsp_err_d    = !op_ok;
      s1_valid_d   = 1'b0;
    end else if (rsp_valid_q && rsp_ready) begin
      rsp_valid_d = 1'b0;
    end

    if (xfer0) begin
      s1_valid_d   = 1'b1;
      s1_id_d      = 1'b0;
      s1_op_d      = req0_op;
      s1_a_d       = req0_a;
      s1_b_d       = req0_b;
      last_grant_d = 1'b0;
    end else if (xfer1) begin
      s1_valid_d   = 1'b1;
      s1_id_d      = 1'b1;
      s1_op_d      = req1_op;
      s1_a_d       = req1_a;
      s1_b_d       = req1_b;
      last_grant_d = 1'b1;
    end
  end

  // State registers; reset discards any in-flight work.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_valid_q   <= 1'b0;
      s1_id_q      <= 1'b0;
      s1_op_q      <= '0;
      s1_a_q       <= '0;
      s1_b_q       <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_result_q <= '0;
      rsp_err_q    <= 1'b0;
      last_grant_q <= 1'b1;
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_id_q      <= s1_id_d;
      s1_op_q      <= s1_op_d;
      s1_a_q       <= s1_a_d;
      s1_b_q       <= s1_b_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_result_q <= rsp_result_d;
      rsp_err_q    <= rsp_err_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign alu_SrcA      = s1_a_q;
  assign alu_SrcB      = s1_b_q;
  assign alu_Operation = s1_op_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_id        = rsp_id_q;
  assign rsp_result    = rsp_result_q;
  assign rsp_err       = rsp_err_q;
  assign busy          = s1_valid_q || rsp_valid_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed self-checking bench for alu_arbiter with a small behavioural ALU.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
// Backpressure is exercised by holding rsp_ready low with a streaming requester.
module tb_alu_arbiter;

  localparam int DW = 32;
  localparam int OW = 26;
  localparam logic [OW-1:0] OP_AND = 26'h1;
  localparam logic [OW-1:0] OP_ADD = 26'h2;
  localparam logic [OW-1:0] OP_SUB = 26'h4;
  localparam logic [OW-1:0] OP_OR  = 26'h8;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          req0_valid = 1'b0, req1_valid = 1'b0;
  logic          req0_ready, req1_ready;
  logic [OW-1:0] req0_op = '0, req1_op = '0;
  logic [DW-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic [DW-1:0] alu_SrcA, alu_SrcB, alu_ALUResult;
  logic [OW-1:0] alu_Operation;
  logic          rsp_valid, rsp_id, rsp_err, busy;
  logic          rsp_ready = 1'b0;
  logic [DW-1:0] rsp_result;

  int n_cmp = 0;
  int n_err = 0;

  alu_arbiter dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b),
    .alu_SrcA(alu_SrcA), .alu_SrcB(alu_SrcB), .alu_Operation(alu_Operation),
    .alu_ALUResult(alu_ALUResult),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_err(rsp_err), .busy(busy)
  );

  always #5 clk = ~clk;

  // Behavioural ALU: undefined or non-one-hot codes yield 0.
  always_comb begin
    case (alu_Operation)
      OP_AND:  alu_ALUResult = alu_SrcA & alu_SrcB;
      OP_ADD:  alu_ALUResult = alu_SrcA + alu_SrcB;
      OP_SUB:  alu_ALUResult = alu_SrcA - alu_SrcB;
      OP_OR:   alu_ALUResult = alu_SrcA | alu_SrcB;
      default: alu_ALUResult = '0;
    endcase
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    step();
    reset = 1'b1;
  endtask

  initial begin
    #20000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // ---- Reset state (req0 already valid to check ready gating) ----
    req0_valid = 1'b1; req0_op = OP_ADD; req0_a = 5; req0_b = 7;
    rsp_ready = 1'b1;
    #2;
    chk("rst_ready0", req0_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_alu_op", alu_Operation, 0);
    chk("rst_rsp_result", rsp_result, 0);
    step();
    reset = 1'b1;

    // ---- Test 1: single ADD, two-cycle latency ----
    @(negedge clk);
    chk("t1_ready_c0", req0_ready, 1);
    step();
    req0_valid = 1'b0;
    @(negedge clk);
    chk("t1_alu_op_c1", alu_Operation, OP_ADD);
    chk("t1_busy_c1", busy, 1);
    chk("t1_rsp_valid_c1", rsp_valid, 0);
    step();
    @(negedge clk);
    chk("t1_rsp_valid_c2", rsp_valid, 1);
    chk("t1_rsp_id", rsp_id, 0);
    chk("t1_rsp_result", rsp_result, 12);
    chk("t1_rsp_err", rsp_err, 0);
    step();
    @(negedge clk);
    chk("t1_rsp_drained", rsp_valid, 0);
    chk("t1_idle", busy, 0);

    // ---- Test 2: both valid, round-robin 0,1,0,1 ----
    do_reset();
    req0_op = OP_SUB; req0_a = 10;   req0_b = 3;
    req1_op = OP_OR;  req1_a = 'hF0; req1_b = 'h0F;
    for (int i = 0; i < 7; i++) begin
      req0_valid = (i < 4);
      req1_valid = (i < 4);
      @(negedge clk);
      if (i < 4) begin
        chk($sformatf("t2_ready0_c%0d", i), req0_ready, (i % 2) == 0);
        chk($sformatf("t2_ready1_c%0d", i), req1_ready, (i % 2) == 1);
      end
      if (i >= 2 && i < 6) begin
        chk($sformatf("t2_rsp_valid_c%0d", i), rsp_valid, 1);
        chk($sformatf("t2_rsp_id_c%0d", i), rsp_id, i % 2);
        chk($sformatf("t2_rsp_result_c%0d", i), rsp_result, (i % 2) ? 'hFF : 7);
      end
      if (i == 6) chk("t2_rsp_done", rsp_valid, 0);
      step();
    end

    // ---- Test 3: backpressure with req0 streaming ----
    rsp_ready = 1'b0;
    req0_valid = 1'b1; req0_op = OP_ADD; req0_a = 1; req0_b = 100;
    @(negedge clk); chk("t3_ready_c0", req0_ready, 1);
    step(); req0_a = 2;
    @(negedge clk); chk("t3_ready_c1", req0_ready, 1);
    step(); req0_a = 3;
    @(negedge clk);
    chk("t3_full_ready_c2", req0_ready, 0);
    chk("t3_hold_result_c2", rsp_result, 101);
    step();
    @(negedge clk);
    chk("t3_full_ready_c3", req0_ready, 0);
    chk("t3_hold_result_c3", rsp_result, 101);
    chk("t3_frozen_srca", alu_SrcA, 2);
    step();
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("t3_passthru_ready", req0_ready, 1);
    chk("t3_first_result", rsp_result, 101);
    step();
    req0_valid = 1'b0;
    @(negedge clk);
    chk("t3_second_valid", rsp_valid, 1);
    chk("t3_second_result", rsp_result, 102);
    step();
    @(negedge clk);
    chk("t3_third_result", rsp_result, 103);
    step();
    @(negedge clk);
    chk("t3_drained", rsp_valid, 0);

    // ---- Test 4: illegal op codes from req1 ----
    step();
    req1_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      case (i)
        0: begin req1_op = 26'h3;      req1_a = 5; req1_b = 7; end
        1: begin req1_op = 26'h800000; req1_a = 5; req1_b = 7; end
        2: begin req1_op = OP_ADD;     req1_a = 2; req1_b = 3; end
        default: req1_valid = 1'b0;
      endcase
      @(negedge clk);
      if (i < 3) chk($sformatf("t4_ready1_c%0d", i), req1_ready, 1);
      if (i >= 2) begin
        chk($sformatf("t4_rsp_id_c%0d", i), rsp_id, 1);
        chk($sformatf("t4_rsp_err_c%0d", i), rsp_err, i < 4);
        chk($sformatf("t4_rsp_result_c%0d", i), rsp_result, (i < 4) ? 0 : 5);
      end
      step();
    end

    // ---- Test 5: asynchronous reset with S1 and S2 full ----
    rsp_ready = 1'b0;
    req0_valid = 1'b1; req0_op = OP_ADD; req0_a = 1; req0_b = 1;
    step(); step();
    @(negedge clk);
    chk("t5_full", req0_ready, 0);
    #1 reset = 1'b0;
    #1;
    chk("t5_rst_rsp_valid", rsp_valid, 0);
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_alu_op", alu_Operation, 0);
    step();
    reset = 1'b1;
    rsp_ready = 1'b1;
    req1_valid = 1'b1; req1_op = OP_ADD; req1_a = 0; req1_b = 0;
    @(negedge clk);
    chk("t5_post_ready0", req0_ready, 1);
    chk("t5_post_ready1", req1_ready, 0);
    step();
    req0_valid = 1'b0; req1_valid = 1'b0;
    step(); step();

    // ---- Test 6: req1 back-to-back, 8 ops ----
    req1_op = OP_ADD; req1_b = 0;
    for (int i = 0; i < 10; i++) begin
      req1_valid = (i < 8);
      req1_a = i;
      @(negedge clk);
      if (i < 8) begin
        chk($sformatf("t6_ready1_c%0d", i), req1_ready, 1);
        chk($sformatf("t6_ready0_c%0d", i), req0_ready, 0);
      end
      if (i >= 2) begin
        chk($sformatf("t6_rsp_valid_c%0d", i), rsp_valid, 1);
        chk($sformatf("t6_rsp_id_c%0d", i), rsp_id, 1);
        chk($sformatf("t6_rsp_result_c%0d", i), rsp_result, i - 2);
      end
      step();
    end
    // last grant was req1, so req0 must win a tie now
    req0_valid = 1'b1; req1_valid = 1'b1;
    @(negedge clk);
    chk("t6_tie_ready0", req0_ready, 1);
    chk("t6_tie_ready1", req1_ready, 0);
    step();
    req0_valid = 1'b0; req1_valid = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
